// File: rtl/dummy_pulpino_write_pkg.sv
// Shared types and constants for the Pulpino-to-USB word-to-byte write path.
package dummy_pulpino_write_pkg;

    // Transfer FSM: idle, or a byte is on out_data waiting for its consume flicker.
    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    localparam int BYTE_W        = 8;
    localparam int DEF_NUM_BYTES = 4;

    // Byte counter width; never narrower than one bit so a 1-byte word still works.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DEF_NUM_BYTES);

endpackage

// File: rtl/dummy_pulpino_write_if.sv
// Bundle of word-side and byte-side flicker handshakes plus status.
//
// Handshake convention: every *_flicker line signals one event per level
// change (toggle), never a pulse. The producer toggles did_word_write_flicker
// with in_word stable; the block toggles did_word_read_flicker once all bytes
// are consumed. On the byte side the block toggles did_byte_write_flicker when
// out_data holds a new byte, and the channel toggles did_byte_read_flicker when
// it has taken that byte.
interface dummy_pulpino_write_if
    import dummy_pulpino_write_pkg::*;
#(
    parameter int NUM_BYTES = DEF_NUM_BYTES
) ();

    logic [BYTE_W*NUM_BYTES-1:0] in_word;
    logic                        did_word_write_flicker;
    logic                        did_word_read_flicker;
    logic [BYTE_W-1:0]           out_data;
    logic                        did_byte_write_flicker;
    logic                        did_byte_read_flicker;
    logic                        busy;
    logic                        overrun;
    state_t                      dbg_state;

    // Block side.
    modport slave (
        input  in_word,
        input  did_word_write_flicker,
        input  did_byte_read_flicker,
        output did_word_read_flicker,
        output out_data,
        output did_byte_write_flicker,
        output busy,
        output overrun,
        output dbg_state
    );

    // Producer / channel side.
    modport master (
        output in_word,
        output did_word_write_flicker,
        output did_byte_read_flicker,
        input  did_word_read_flicker,
        input  out_data,
        input  did_byte_write_flicker,
        input  busy,
        input  overrun,
        input  dbg_state
    );

endinterface

// File: rtl/dummy_pulpino_write_flicker_event_detect.sv
// Turns a flicker (toggle-coded) line into a one-cycle event strobe.
module flicker_event_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic flicker,
    output logic event_o
);

    logic prev_d;
    logic prev_q;

    // Next previous-level is simply the current line level.
    always_comb begin
        prev_d = flicker;
    end

    // Previous-level register; resets to 0 so the line must start at 0 too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign event_o = flicker ^ prev_q;

endmodule

// File: rtl/dummy_pulpino_write.sv
// Serialises one NUM_BYTES-wide word into bytes, one per byte-consumed flicker.
module dummy_pulpino_write
    import dummy_pulpino_write_pkg::*;
#(
    parameter int NUM_BYTES = DEF_NUM_BYTES,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    dummy_pulpino_write_if.slave bus
);

    localparam int WORD_W = BYTE_W * NUM_BYTES;
    localparam int CW     = cnt_width(NUM_BYTES);
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_BYTES - 1);

    logic word_ev;
    logic byte_ev;

    state_t            state_d,    state_q;
    logic [CW-1:0]     count_d,    count_q;
    logic [WORD_W-1:0] shift_d,    shift_q;
    logic [BYTE_W-1:0] out_data_d, out_data_q;
    logic              byte_flk_d, byte_flk_q;
    logic              word_flk_d, word_flk_q;
    logic              busy_d,     busy_q;
    logic              overrun_d,  overrun_q;

    logic [WORD_W-1:0] shift_nx;
    logic              last_ack;

    // The byte that goes out first (or next) is at the head of the shift register.
    function automatic logic [BYTE_W-1:0] head_byte(input logic [WORD_W-1:0] w);
        return MSB_FIRST ? w[WORD_W-1 -: BYTE_W] : w[BYTE_W-1:0];
    endfunction

    flicker_event_detect u_word_ev (
        .clk     (clk),
        .rst_n   (rst_n),
        .flicker (bus.did_word_write_flicker),
        .event_o (word_ev)
    );

    flicker_event_detect u_byte_ev (
        .clk     (clk),
        .rst_n   (rst_n),
        .flicker (bus.did_byte_read_flicker),
        .event_o (byte_ev)
    );

    // Shift register contents after dropping the byte just consumed.
    always_comb begin
        shift_nx = MSB_FIRST ? (shift_q << BYTE_W) : (shift_q >> BYTE_W);
    end

    // Next-state and output logic for the transfer FSM.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        shift_d    = shift_q;
        out_data_d = out_data_q;
        byte_flk_d = byte_flk_q;
        word_flk_d = word_flk_q;
        busy_d     = busy_q;
        overrun_d  = overrun_q;
        last_ack   = 1'b0;

        case (state_q)
            IDLE: begin
                // A simultaneous byte event here is stale and deliberately ignored.
                if (word_ev) begin
                    shift_d    = bus.in_word;
                    out_data_d = head_byte(bus.in_word);
                    byte_flk_d = ~byte_flk_q;
                    count_d    = '0;
                    busy_d     = 1'b1;
                    state_d    = WAIT_ACK;
                end
            end

            WAIT_ACK: begin
                last_ack = byte_ev && (count_q == LAST_CNT);

                // A word offered mid-transfer is dropped; only the final-ack
                // edge can accept the next word back-to-back.
                if (word_ev && !last_ack) begin
                    overrun_d = 1'b1;
                end

                if (byte_ev) begin
                    if (!last_ack) begin
                        count_d    = count_q + CW'(1);
                        shift_d    = shift_nx;
                        out_data_d = head_byte(shift_nx);
                        byte_flk_d = ~byte_flk_q;
                    end else begin
                        word_flk_d = ~word_flk_q;
                        if (word_ev) begin
                            shift_d    = bus.in_word;
                            out_data_d = head_byte(bus.in_word);
                            byte_flk_d = ~byte_flk_q;
                            count_d    = '0;
                        end else begin
                            // out_data keeps the last byte on purpose.
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            shift_q    <= '0;
            out_data_q <= '0;
            byte_flk_q <= 1'b0;
            word_flk_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            out_data_q <= out_data_d;
            byte_flk_q <= byte_flk_d;
            word_flk_q <= word_flk_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.out_data               = out_data_q;
    assign bus.did_byte_write_flicker = byte_flk_q;
    assign bus.did_word_read_flicker  = word_flk_q;
    assign bus.busy                   = busy_q;
    assign bus.overrun                = overrun_q;
    assign bus.dbg_state              = state_q;

endmodule

// File: doc/dummy_pulpino_write.md
Name: dummy_pulpino_write

Overview:
Pulpino-to-USB counterpart of the word-to-byte path. It takes a 32-bit word from the Pulpino-side producer and serialises it into bytes on the channel's pulpino_to_usb_data / pulpino_write_flicker inputs, pacing each byte on the channel's byte-consumed flicker. All handshakes use the codebase's flicker convention: an event is any level change (toggle) of a single-bit line, not a pulse.

Parameters:
NUM_BYTES, 4, bytes per word; in_word width = 8*NUM_BYTES.
MSB_FIRST, 1, 1 = most-significant byte sent first; 0 = least-significant first.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_word  input  8*NUM_BYTES  word to send; must be stable from its write-flicker toggle until did_word_read_flicker toggles.
did_word_write_flicker  input  1  toggles once per new word offered.
did_word_read_flicker  output  1  toggles once when all bytes of the word have been consumed.
out_data  output  8  current byte, connects to channel pulpino_to_usb_data.
did_byte_write_flicker  output  1  toggles when out_data holds a new byte, connects to channel pulpino_write_flicker.
did_byte_read_flicker  input  1  toggles when the channel has consumed out_data.
busy  output  1  high while a word is in flight.
overrun  output  1  sticky; set when a word is offered while busy.

Behaviour:
- Inputs are synchronous to clk. Event detection: register previous level of each flicker input (reset 0); event = input XOR previous.
- Reset values: out_data 0, did_byte_write_flicker 0, did_word_read_flicker 0, busy 0, overrun 0, FSM IDLE, byte counter 0, shift register 0.
- FSM states: IDLE, WAIT_ACK.
- IDLE + word event at edge E:
  - capture in_word into the shift register;
  - drive byte 0 onto out_data;
  - toggle did_byte_write_flicker;
  - set count = 0 and busy = 1;
  - go to WAIT_ACK.
  - New byte and toggle are visible after E (1-cycle latency from word toggle).
- WAIT_ACK + byte event, count < NUM_BYTES-1: count++, advance shift register, drive next byte, toggle did_byte_write_flicker in the same edge; stay in WAIT_ACK.
- WAIT_ACK + byte event, count == NUM_BYTES-1:
  - toggle did_word_read_flicker;
  - clear busy;
  - go to IDLE;
  - out_data holds the last byte.
- Byte order: MSB_FIRST=1 sends in_word[31:24], [23:16], [15:8], [7:0]. MSB_FIRST=0 sends the reverse order.
- Word event in WAIT_ACK, except on the final-ack edge:
  - set overrun = 1;
  - discard the new word;
  - the current transfer continues unchanged.
- Word event on the same edge as the final byte ack: accepted as back-to-back.
  - toggle did_word_read_flicker;
  - capture the new word;
  - emit its byte 0 with a did_byte_write_flicker toggle;
  - stay in WAIT_ACK with busy held at 1.
- Byte event in IDLE: ignored, no output change.
- Both inputs toggling at once in IDLE: the word event is handled; the byte event is ignored.
- overrun is cleared only by rst_n.
- Reset mid-transfer: immediate return to reset values. Later acks are ignored until a new word event. Flicker outputs restart from 0, so the consumer must be reset together with this block.

Decomposition:
- Shared package holds:
  - state enum {IDLE, WAIT_ACK};
  - localparam BYTE_W = 8;
  - count width localparam = clog2(NUM_BYTES).
- One natural sub-module: flicker_event_detect (1-bit previous-level register plus XOR, async active-low reset). Instantiated twice, and reusable by the read-side block.

Test Plan:
1. Reset: hold rst_n=0 for 8 cycles -> out_data=0x00, both flicker outputs 0, busy=0, overrun=0.
2. MSB_FIRST=1, in_word=32'h1234_1236, toggle word flicker; then toggle byte-read flicker once per byte.
   - One cycle after the word toggle: out_data=0x12 and did_byte_write_flicker=1.
   - Each ack then yields 0x34, 0x12, 0x36, each with a toggle.
   - The 4th ack toggles did_word_read_flicker and drops busy.
3. MSB_FIRST=0, same word -> byte sequence 0x36, 0x12, 0x34, 0x12.
4. Overrun: after the first byte of 32'hAABB_CCDD, toggle word flicker with in_word=32'h1111_1111.
   - overrun=1.
   - Remaining bytes are still 0xBB, 0xCC, 0xDD.
   - Exactly one did_word_read_flicker toggle occurs.
5. Back-to-back: toggle word flicker (in_word=32'h5566_7788) on the same cycle as the 4th ack of 32'h1234_1236.
   - Same edge: did_word_read_flicker toggles, out_data=0x55, did_byte_write_flicker toggles, busy stays 1.
   - overrun stays 0.
6. Reset mid-word: assert rst_n=0 after 2 bytes of 32'h1234_1236.
   - Outputs return to reset values.
   - Subsequent byte-read toggles produce no output change while IDLE.
